// File: rtl/id_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage hazard controller: RV32 opcode classes (inst[6:2])
// and the sequencing FSM state encoding.
package id_hazard_ctrl_pkg;

  localparam logic [4:0] OpR  = 5'b01100;
  localparam logic [4:0] OpIi = 5'b00100;
  localparam logic [4:0] OpIj = 5'b11001;
  localparam logic [4:0] OpIl = 5'b00000;
  localparam logic [4:0] OpS  = 5'b01000;
  localparam logic [4:0] OpB  = 5'b11000;
  localparam logic [4:0] OpUl = 5'b01101;
  localparam logic [4:0] OpUa = 5'b00101;
  localparam logic [4:0] OpJ  = 5'b11011;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLstall = 2'd1,
    StFlush  = 2'd2,
    StFreeze = 2'd3
  } state_e;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Pipeline-control bundle between the ID-stage controller (slave) and the pipeline (master).
interface id_hazard_ctrl_if;

  logic [31:0] id_inst;
  logic        id_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        dmem_busy;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_stall;
  logic        idex_bubble;
  logic [1:0]  ctrl_state;

  modport master (
    output id_inst, id_valid, ex_mem_read, ex_rd, ex_redirect, dmem_busy,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, ctrl_state
  );

  modport slave (
    input  id_inst, id_valid, ex_mem_read, ex_rd, ex_redirect, dmem_busy,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, ctrl_state
  );

endinterface

// File: rtl/id_hazard_ctrl_reg_use.sv
// Combinational source-register usage decode for the instruction sitting in IF/ID.
module id_reg_use
  import id_hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic unused_bits;

  // Only the opcode class and the two register fields matter here.
  assign unused_bits = ^{id_inst[31:25], id_inst[14:7], id_inst[1:0]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_inst[6:2])
      OpR, OpS, OpB: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpIi, OpIl, OpIj: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencing controller: load-use stalls, redirect flushes and dmem freezes.
// Optional build macro HAZARD_STAT_EN adds free-running event statistics ports.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                clk,
  input  logic                rst,
  id_hazard_ctrl_if.slave     bus
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]         stat_stall_cnt,
  output logic [31:0]         stat_flush_cnt,
  output logic [31:0]         stat_freeze_cnt
`endif
);

  localparam logic [CNT_W-1:0] LuInit = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FlInit = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d, saved_q, saved_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic             use_rs1, use_rs2, hazard;
  logic [4:0]       rs1, rs2;
  logic             do_stall, do_flush, do_freeze;

  id_reg_use u_reg_use (
    .id_inst (bus.id_inst),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .rs1     (rs1),
    .rs2     (rs2)
  );

  assign hazard = bus.id_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                  ((use_rs1 & (rs1 == bus.ex_rd)) | (use_rs2 & (rs2 == bus.ex_rd)));

  always_comb begin
    // While frozen, the interrupted sequence resumes the moment dmem_busy drops.
    eff_state   = (state_q == StFreeze) ? saved_q : state_q;
    eff_cnt     = (state_q == StFreeze) ? saved_cnt_q : cnt_q;
    state_d     = eff_state;
    cnt_d       = eff_cnt;
    saved_d     = saved_q;
    saved_cnt_d = saved_cnt_q;
    do_stall    = 1'b0;
    do_flush    = 1'b0;
    do_freeze   = 1'b0;
    if (bus.dmem_busy) begin
      do_freeze   = 1'b1;
      state_d     = StFreeze;
      cnt_d       = cnt_q;
      saved_d     = eff_state;
      saved_cnt_d = eff_cnt;
    end else if (bus.ex_redirect) begin
      do_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = FlInit;
      end else begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end else begin
      unique case (eff_state)
        StRun: begin
          if (hazard) begin
            do_stall = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              state_d = StLstall;
              cnt_d   = LuInit;
            end
          end
        end
        StLstall, StFlush: begin
          do_stall = (eff_state == StLstall);
          do_flush = (eff_state == StFlush);
          if (eff_cnt <= CntOne) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = eff_cnt - CntOne;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      saved_q     <= StRun;
      saved_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      saved_q     <= saved_d;
      saved_cnt_q <= saved_cnt_d;
    end
  end

  always_comb begin
    if (rst) begin
      bus.pc_stall    = 1'b0;
      bus.ifid_stall  = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_stall  = 1'b0;
      bus.idex_bubble = 1'b1;
      bus.ctrl_state  = 2'd0;
    end else begin
      bus.pc_stall    = do_stall | do_freeze;
      bus.ifid_stall  = do_stall | do_freeze;
      bus.ifid_flush  = do_flush;
      bus.idex_stall  = do_freeze;
      bus.idex_bubble = do_stall | do_flush;
      bus.ctrl_state  = state_q;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (do_stall)              stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (do_flush)              flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (state_q == StFreeze)   freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign stat_stall_cnt  = stall_cnt_q;
  assign stat_flush_cnt  = flush_cnt_q;
  assign stat_freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl built with LOAD_USE_CYCLES=3, FLUSH_CYCLES=2.
module tb_id_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Output groups, packed as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble}.
  localparam logic [4:0] Idle   = 5'b00000;
  localparam logic [4:0] Stall  = 5'b11001;
  localparam logic [4:0] Flush  = 5'b00101;
  localparam logic [4:0] Freeze = 5'b11010;

  localparam logic [31:0] InstAdd = 32'h002081B3;
  localparam logic [31:0] InstSw  = 32'h0050A023;
  localparam logic [31:0] InstLui = 32'h00008137;

  id_hazard_ctrl_if bus ();

`ifdef HAZARD_STAT_EN
  logic [31:0] stat_stall_cnt, stat_flush_cnt, stat_freeze_cnt;
`endif

  id_hazard_ctrl #(
    .LOAD_USE_CYCLES (3),
    .FLUSH_CYCLES    (2),
    .CNT_W           (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef HAZARD_STAT_EN
    ,
    .stat_stall_cnt  (stat_stall_cnt),
    .stat_flush_cnt  (stat_flush_cnt),
    .stat_freeze_cnt (stat_freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] inst, input logic valid, input logic mr,
                       input logic [4:0] rd, input logic redir, input logic busy);
    bus.id_inst     = inst;
    bus.id_valid    = valid;
    bus.ex_mem_read = mr;
    bus.ex_rd       = rd;
    bus.ex_redirect = redir;
    bus.dmem_busy   = busy;
  endtask

  // Check mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [4:0] exp_o, input logic [1:0] exp_st);
    logic [6:0] got;
    logic [6:0] want;
    #3;
    got  = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_stall, bus.idex_bubble,
            bus.ctrl_state};
    want = {exp_o, exp_st};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_STAT_EN
  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask
`endif

  initial begin
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset", Flush, 2'd0);
    rst = 1'b0;
    cyc("idle", Idle, 2'd0);

    // add x3,x1,x2 after load to x1: three stall cycles then run
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("lu_add0", Stall, 2'd0);
    cyc("lu_add1", Stall, 2'd1);
    cyc("lu_add2", Stall, 2'd1);
    drive(InstAdd, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
    cyc("lu_add_end", Idle, 2'd0);
    drive(InstAdd, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("lu_invalid", Idle, 2'd0);

    // sw x5,0(x1): rs2 hazard, then x0 never hazards
    drive(InstSw, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc("lu_sw0", Stall, 2'd0);
    cyc("lu_sw1", Stall, 2'd1);
    cyc("lu_sw2", Stall, 2'd1);
    drive(InstSw, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc("lu_sw_x0", Idle, 2'd0);

    // lui has no sources even though its rs1 field matches
    drive(InstLui, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("lu_lui", Idle, 2'd0);

    // redirect beats a simultaneous hazard: two flush cycles, no pc stall
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    cyc("redir0", Flush, 2'd0);
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("redir1", Flush, 2'd2);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("redir_end", Idle, 2'd0);

    // freeze in the middle of a load-use stall resumes the remaining two cycles
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("lf_stall0", Stall, 2'd0);
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
    cyc("lf_frz0", Freeze, 2'd1);
    cyc("lf_frz1", Freeze, 2'd3);
    cyc("lf_frz2", Freeze, 2'd3);
    cyc("lf_frz3", Freeze, 2'd3);
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("lf_stall1", Stall, 2'd3);
    cyc("lf_stall2", Stall, 2'd1);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("lf_end", Idle, 2'd0);

    // redirect aborts a load-use stall
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    cyc("abort_stall", Stall, 2'd0);
    drive(InstAdd, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    cyc("abort_fl0", Flush, 2'd1);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("abort_fl1", Flush, 2'd2);
    cyc("abort_end", Idle, 2'd0);

    // freeze from idle run
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc("frz_run0", Freeze, 2'd0);
    cyc("frz_run1", Freeze, 2'd3);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc("frz_run_rel", Idle, 2'd3);
    cyc("frz_run_end", Idle, 2'd0);

`ifdef HAZARD_STAT_EN
    chk32("stat_stall", stat_stall_cnt, 32'd10);
    chk32("stat_flush", stat_flush_cnt, 32'd4);
    chk32("stat_freeze", stat_freeze_cnt, 32'd6);
`endif

    // reset in the middle of a flush sequence
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc("rfl_flush", Flush, 2'd0);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rfl_rst", Flush, 2'd0);
    rst = 1'b0;
    cyc("rfl_after", Idle, 2'd0);

`ifdef HAZARD_STAT_EN
    chk32("stat_clr", stat_flush_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
